vga_xga_timing_gen: RTL and testbench
=====================================

// Module: vga_xga_timing_gen
// PURPOSE
//   Raster timing generator for the TinyQV VGA text console. Runs off the 64 MHz project clock
//   (1024x768@60 XGA, pixel clock nominally 65 MHz). Feeds the text renderer directly with
//   sync, blank, split X/Y coordinates and a vertical-blank interrupt.
//   Split coordinates (X in 32-px units, Y in 48-line units) let the renderer decode regions
//   with shifts and adds only.
// PARAMETERS
//   H_VISIBLE 1024  visible pixels per line (multiple of 32)
//   H_FRONT   24    horizontal front porch, pixels
//   H_SYNC    136   hsync pulse width, pixels
//   H_BACK    160   horizontal back porch; H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK=1344 (multiple of 32)
//   V_VISIBLE 768   visible lines (multiple of 48)
//   V_FRONT   3     vertical front porch, lines
//   V_SYNC    6     vsync pulse width, lines
//   V_BACK    29    vertical back porch; V_TOTAL=806
//   HSYNC_POL 0     active level of hsync (0 = negative pulse)
//   VSYNC_POL 0     active level of vsync (0 = negative pulse)
// PORTS
//   clk        in   1  project clock
//   rst_n      in   1  asynchronous active-low reset
//   hsync      out  1  horizontal sync, polarity HSYNC_POL
//   vsync      out  1  vertical sync, polarity VSYNC_POL
//   blank      out  1  1 outside the visible area
//   interrupt  out  1  vertical-blank interrupt, sticky until cli
//   cli        in   1  clear interrupt, sampled on the clk edge
//   x_lo       out  5  X mod 32
//   x_hi       out  6  X div 32, range 0..41
//   y_lo       out  6  Y mod 48
//   y_hi       out  5  Y div 48, range 0..16
// BEHAVIOUR
// - Position and advance
//   - State is 4 registers: x_lo, x_hi, y_lo, y_hi. X = 32*x_hi + x_lo. Y = 48*y_hi + y_lo.
//   - No full-width X or Y register exists.
//   - Each clk: x_lo+1. On x_lo=31, x_lo->0 and x_hi+1.
//   - At X=H_TOTAL-1 (x_hi=41, x_lo=31), X wraps to 0 and the line advances.
//   - Line advance: y_lo+1. On y_lo=47, y_lo->0 and y_hi+1.
//   - At Y=V_TOTAL-1 (y_hi=16, y_lo=37), Y wraps to 0 on the X wrap.
//   - X is continuous (no skipped or repeated values); the renderer depends on X=31 recurring every line.
// - Sync and blank
//   - hsync, vsync and blank are registers. Each is loaded from a decode of the next-state counters,
//     so it is valid in the same cycle as the coordinates it describes. Latency 0 relative to the
//     coordinates; no glitches.
//   - blank = (X >= H_VISIBLE) | (Y >= V_VISIBLE).
//   - hsync active for X in [1048,1184), i.e. x_hi=32,x_lo>=24 through x_hi=36.
//   - vsync active for Y in [771,777), i.e. y_hi=16, y_lo 3..8, for whole lines. vsync changes only
//     on the X wrap edge.
// - Interrupt
//   - Set event: the cycle the counters enter X=0, Y=V_VISIBLE (768), i.e. the start of vertical blank.
//   - interrupt rises on that edge and stays high until a clk edge with cli=1.
//   - Set and cli on the same edge: set wins, interrupt stays 1.
//   - cli while interrupt=0: no effect.
//   - Exactly one set event per frame.
// - Reset
//   - rst_n low asynchronously forces: all counters 0 (X=0,Y=0), blank=0, hsync=~HSYNC_POL,
//     vsync=~VSYNC_POL, interrupt=0.
//   - Reset mid-frame restarts at the top-left; the first frame after release is full length.
//   - The first clk after release advances to X=1.
// - Frame timing
//   - 1344*806 = 1,083,264 clk per frame; no other state.
// TESTING
// - Reset release, run 1344 clk -> x_hi:x_lo sequence 0..1343, then X=0 with y_lo=1. blank=0 for X<1024, 1 after.
// - Line 0 hsync -> falls at X=1048, rises at X=1184. Width exactly 136 clk; repeats with a 1344-clk period.
// - Full frame -> vsync low for exactly 6*1344 clk starting at Y=771,X=0. Y wraps 805->0. Frame = 1,083,264 clk.
// - interrupt rises on entry to X=0,Y=768. cli pulse 10 clk later -> 0 next edge. No re-assert until the next frame.
// - cli held high on the set edge -> interrupt=1. Assert rst_n=0 at Y=400 -> outputs at reset values immediately, restart at 0,0.
// - y_hi/y_lo decode check -> Y=200 shows y_hi=4,y_lo=8. Y=767 shows y_hi=15,y_lo=47. Y=768 shows y_hi=16,y_lo=0.

Source files
------------

// File: rtl/vga_xga_timing_gen.sv
// XGA raster timing generator for the VGA text console.
// Split X/Y counters with registered sync/blank decoded from the next state.
module vga_xga_timing_gen #(
   parameter int H_VISIBLE = 1024,
   parameter int H_FRONT   = 24,
   parameter int H_SYNC    = 136,
   parameter int H_BACK    = 160,
   parameter int V_VISIBLE = 768,
   parameter int V_FRONT   = 3,
   parameter int V_SYNC    = 6,
   parameter int V_BACK    = 29,
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       hsync,
   output logic       vsync,
   output logic       blank,
   output logic       interrupt,
   input  logic       cli,
   output logic [4:0] x_lo,
   output logic [5:0] x_hi,
   output logic [5:0] y_lo,
   output logic [4:0] y_hi
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [5:0]  X_HI_LAST = 6'(H_TOTAL / 32 - 1);
   localparam logic [4:0]  Y_HI_LAST = 5'((V_TOTAL - 1) / 48);
   localparam logic [5:0]  Y_LO_LAST = 6'((V_TOTAL - 1) % 48);
   localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic        x_wrap;
   logic        y_wrap;
   logic [4:0]  nx_lo;
   logic [5:0]  nx_hi;
   logic [5:0]  ny_lo;
   logic [4:0]  ny_hi;
   logic [10:0] nx;
   logic [10:0] ny;
   logic        hs_act;
   logic        vs_act;
   logic        blank_nxt;
   logic        irq_set;

   always_comb begin
      x_wrap = (x_hi == X_HI_LAST) && (x_lo == 5'd31);
      y_wrap = (y_hi == Y_HI_LAST) && (y_lo == Y_LO_LAST);
      nx_lo  = x_lo + 5'd1;
      nx_hi  = x_hi;
      ny_lo  = y_lo;
      ny_hi  = y_hi;
      if (x_lo == 5'd31) begin
         nx_hi = x_wrap ? 6'd0 : x_hi + 6'd1;
      end
      if (x_wrap) begin
         if (y_wrap) begin
            ny_lo = 6'd0;
            ny_hi = 5'd0;
         end else if (y_lo == 6'd47) begin
            ny_lo = 6'd0;
            ny_hi = y_hi + 5'd1;
         end else begin
            ny_lo = y_lo + 6'd1;
         end
      end
      // Full-width positions exist only as decode wires: 48*y = 32*y + 16*y
      nx = {nx_hi, nx_lo};
      ny = {1'b0, ny_hi, 5'b0} + {2'b0, ny_hi, 4'b0} + {5'b0, ny_lo};
      hs_act    = (nx >= HS_START) && (nx < HS_END);
      vs_act    = (ny >= VS_START) && (ny < VS_END);
      blank_nxt = (nx >= H_VIS) || (ny >= V_VIS);
      irq_set   = (nx == 11'd0) && (ny == V_VIS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_lo      <= '0;
         x_hi      <= '0;
         y_lo      <= '0;
         y_hi      <= '0;
         hsync     <= ~HSYNC_POL;
         vsync     <= ~VSYNC_POL;
         blank     <= 1'b0;
         interrupt <= 1'b0;
      end else begin
         x_lo      <= nx_lo;
         x_hi      <= nx_hi;
         y_lo      <= ny_lo;
         y_hi      <= ny_hi;
         hsync     <= hs_act ? HSYNC_POL : ~HSYNC_POL;
         vsync     <= vs_act ? VSYNC_POL : ~VSYNC_POL;
         blank     <= blank_nxt;
         interrupt <= irq_set | (interrupt & ~cli);
      end
   end

endmodule

// File: tb/tb_vga_xga_timing_gen.sv
// Bench for vga_xga_timing_gen: default XGA instance for line timing,
// short-line instance (64 clk lines, full 806-line frame) for frame/irq.
module tb_vga_xga_timing_gen;

   localparam int T_RST = 77184 + 44;

   logic clk = 1'b0;
   logic rst_n;
   logic cli;
   logic cli_d;

   logic       d_hsync, d_vsync, d_blank, d_irq;
   logic [4:0] d_x_lo;
   logic [5:0] d_x_hi;
   logic [5:0] d_y_lo;
   logic [4:0] d_y_hi;

   logic       s_hsync, s_vsync, s_blank, s_irq;
   logic [4:0] s_x_lo;
   logic [5:0] s_x_hi;
   logic [5:0] s_y_lo;
   logic [4:0] s_y_hi;

   int n_checks = 0;
   int n_fail   = 0;
   int t        = 0;

   always #5 clk = ~clk;

   vga_xga_timing_gen u_xga (
      .clk(clk), .rst_n(rst_n), .hsync(d_hsync), .vsync(d_vsync),
      .blank(d_blank), .interrupt(d_irq), .cli(cli_d),
      .x_lo(d_x_lo), .x_hi(d_x_hi), .y_lo(d_y_lo), .y_hi(d_y_hi)
   );

   vga_xga_timing_gen #(
      .H_VISIBLE(32), .H_FRONT(8), .H_SYNC(8), .H_BACK(16)
   ) u_short (
      .clk(clk), .rst_n(rst_n), .hsync(s_hsync), .vsync(s_vsync),
      .blank(s_blank), .interrupt(s_irq), .cli(cli),
      .x_lo(s_x_lo), .x_hi(s_x_hi), .y_lo(s_y_lo), .y_hi(s_y_hi)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s t=%0d got %0d expected %0d", tag, t, obs, exp);
      end
   endtask

   function automatic int xpos(input logic [5:0] hi, input logic [4:0] lo);
      return int'(hi) * 32 + int'(lo);
   endfunction

   function automatic int ypos(input logic [4:0] hi, input logic [5:0] lo);
      return int'(hi) * 48 + int'(lo);
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_dx"}, xpos(d_x_hi, d_x_lo), 0);
      check({tag, "_dy"}, ypos(d_y_hi, d_y_lo), 0);
      check({tag, "_dhs"}, int'(d_hsync), 1);
      check({tag, "_dvs"}, int'(d_vsync), 1);
      check({tag, "_dbl"}, int'(d_blank), 0);
      check({tag, "_sx"}, xpos(s_x_hi, s_x_lo), 0);
      check({tag, "_sy"}, ypos(s_y_hi, s_y_lo), 0);
      check({tag, "_shs"}, int'(s_hsync), 1);
      check({tag, "_svs"}, int'(s_vsync), 1);
      check({tag, "_sbl"}, int'(s_blank), 0);
      check({tag, "_sirq"}, int'(s_irq), 0);
   endtask

   initial begin
      int xd, yd, xs, ys;
      int hs_low, hs_first, vs_low, vs_first;
      bit irq_m;
      rst_n    = 1'b0;
      cli      = 1'b0;
      cli_d    = 1'b0;
      irq_m    = 1'b0;
      hs_low   = 0;
      hs_first = -1;
      vs_low   = 0;
      vs_first = -1;
      repeat (2) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;

      for (int i = 1; i <= T_RST; i++) begin
         @(posedge clk);
         @(negedge clk);
         t  = i;
         xd = i % 1344;
         yd = (i / 1344) % 806;
         xs = i % 64;
         ys = (i / 64) % 806;
         if (xs == 0 && ys == 768) irq_m = 1'b1;
         else if (cli) irq_m = 1'b0;

         if (i <= 4032) begin
            check("d_x", xpos(d_x_hi, d_x_lo), xd);
            check("d_y", ypos(d_y_hi, d_y_lo), yd);
            check("d_blank", int'(d_blank), int'(xd >= 1024));
            check("d_hsync", int'(d_hsync), int'(!(xd >= 1048 && xd < 1184)));
            check("d_vsync", int'(d_vsync), 1);
            check("d_irq", int'(d_irq), 0);
         end
         if (i <= 1344 && !d_hsync) begin
            hs_low++;
            if (hs_first < 0) hs_first = i;
         end
         if (i <= 51584 && !s_vsync) begin
            vs_low++;
            if (vs_first < 0) vs_first = i;
         end

         check("s_x", xpos(s_x_hi, s_x_lo), xs);
         check("s_y", ypos(s_y_hi, s_y_lo), ys);
         check("s_blank", int'(s_blank), int'(xs >= 32 || ys >= 768));
         check("s_hsync", int'(s_hsync), int'(!(xs >= 40 && xs < 48)));
         check("s_vsync", int'(s_vsync), int'(!(ys >= 771 && ys < 777)));
         check("s_irq", int'(s_irq), int'(irq_m));

         case (i)
            1: check("first_x", xpos(d_x_hi, d_x_lo), 1);
            1344: begin
               check("line_wrap_ylo", int'(d_y_lo), 1);
               check("hs_width", hs_low, 136);
               check("hs_fall", hs_first, 1048);
            end
            2688 + 1048: check("hs_period", int'(d_hsync), 0);
            200 * 64: begin
               check("y200_hi", int'(s_y_hi), 4);
               check("y200_lo", int'(s_y_lo), 8);
            end
            767 * 64: begin
               check("y767_hi", int'(s_y_hi), 15);
               check("y767_lo", int'(s_y_lo), 47);
               check("y767_blank", int'(s_blank), 0);
            end
            768 * 64: begin
               check("y768_hi", int'(s_y_hi), 16);
               check("y768_lo", int'(s_y_lo), 0);
               check("irq_set_cli", int'(s_irq), 1);
            end
            49161: check("irq_hold", int'(s_irq), 1);
            49162: check("irq_clr", int'(s_irq), 0);
            51583: begin
               check("ylast_hi", int'(s_y_hi), 16);
               check("ylast_lo", int'(s_y_lo), 37);
            end
            51584: begin
               check("frame_wrap", ypos(s_y_hi, s_y_lo), 0);
               check("vs_width", vs_low, 384);
               check("vs_fall", vs_first, 49344);
            end
            default: ;
         endcase

         cli = (i + 1 == 49151) || (i + 1 == 49152) || (i + 1 == 49162);
      end

      check("pre_rst_y", ypos(s_y_hi, s_y_lo), 400);
      check("pre_rst_hs", int'(s_hsync), 0);
      rst_n = 1'b0;
      #1;
      check_reset("async");
      @(posedge clk);
      @(negedge clk);
      check_reset("hold");
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rel_dx", xpos(d_x_hi, d_x_lo), 1);
      check("rel_sx", xpos(s_x_hi, s_x_lo), 1);
      check("rel_sy", ypos(s_y_hi, s_y_lo), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
